// File: rtl/pc_next_pkg.sv
// Shared constants and select-code names for the PC next-source selector.
package pc_next_pkg;

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned PC_INC   = 4;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  // Select codes for the default five-source configuration.
  typedef enum logic [2:0] {
    PC_SRC_SEQ_ALT = 3'd0,
    PC_SRC_BRANCH  = 3'd1,
    PC_SRC_JUMP    = 3'd2,
    PC_SRC_JR      = 3'd3,
    PC_SRC_EXC     = 3'd4
  } pc_src_e;

endpackage

// File: rtl/pc_src_mux.sv
// Combinational NUM_SRC:1 word mux; o_in_range flags a select that names a real source.
module pc_src_mux #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 5,
  parameter int unsigned SEL_W   = 3
) (
  input  logic [NUM_SRC*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]         i_sel,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_in_range
);

  always_comb begin
    o_data     = '0;
    o_in_range = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_data     = i_data[k*WIDTH +: WIDTH];
        o_in_range = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_next_sel.sv
// Architectural PC register with redirect select and one-entry pending-redirect buffer.
// Optional misaligned-target drop enabled by defining PC_ALIGN_CHECK_EN (adds align_err).
module pc_next_sel
  import pc_next_pkg::*;
#(
  parameter int unsigned      WIDTH    = PC_WIDTH,
  parameter int unsigned      NUM_SRC  = 5,
  parameter int unsigned      SEL_W    = 3,
  parameter int unsigned      INC      = PC_INC,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     sel_valid,
  input  logic                     stall,
  output logic [WIDTH-1:0]         pc,
  output logic                     pc_valid,
  output logic                     redirect_pending,
  output logic                     sel_err
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                     align_err
`endif
);

  logic [WIDTH-1:0] r_pc;
  logic             r_pc_valid;
  logic             r_pend_v;
  logic [WIDTH-1:0] r_pend_tgt;
  logic             r_sel_err;

  logic [WIDTH-1:0] w_mux_data;
  logic             w_in_range;
  logic             w_req_ok;
  logic             w_req_bad;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             w_pend_v_nxt;
  logic [WIDTH-1:0] w_pend_tgt_nxt;
  logic             w_apply;
  logic [WIDTH-1:0] w_apply_tgt;
  logic             w_align_bad;

  pc_src_mux #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_mux (
    .i_data     (src_data),
    .i_sel      (sel),
    .o_data     (w_mux_data),
    .o_in_range (w_in_range)
  );

  assign w_req_ok  = sel_valid & w_in_range;
  assign w_req_bad = sel_valid & ~w_in_range;

`ifdef PC_ALIGN_CHECK_EN
  assign w_align_bad = w_apply & (w_apply_tgt[1:0] != 2'b00);
`else
  assign w_align_bad = 1'b0;
`endif

  always_comb begin
    w_pc_nxt       = r_pc;
    w_pend_v_nxt   = r_pend_v;
    w_pend_tgt_nxt = r_pend_tgt;
    w_apply        = 1'b0;
    w_apply_tgt    = r_pend_tgt;
    if (w_req_bad) begin
      // Out-of-range select freezes everything for one cycle, pending included.
      w_pc_nxt = r_pc;
    end else if (stall) begin
      if (w_req_ok) begin
        w_pend_v_nxt   = 1'b1;
        w_pend_tgt_nxt = w_mux_data;
      end
    end else if (w_req_ok) begin
      w_apply      = 1'b1;
      w_apply_tgt  = w_mux_data;
      w_pend_v_nxt = 1'b0;
    end else if (r_pend_v) begin
      w_apply      = 1'b1;
      w_apply_tgt  = r_pend_tgt;
      w_pend_v_nxt = 1'b0;
    end else begin
      w_pc_nxt = r_pc + WIDTH'(INC);
    end
    if (w_apply && !w_align_bad) begin
      w_pc_nxt = w_apply_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_pc_valid <= 1'b0;
      r_pend_v   <= 1'b0;
      r_pend_tgt <= '0;
      r_sel_err  <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_pc_valid <= 1'b1;
      r_pend_v   <= w_pend_v_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      r_sel_err  <= w_req_bad;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic r_align_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_align_err <= 1'b0;
    else        r_align_err <= w_align_bad;
  end
  assign align_err = r_align_err;
`endif

  assign pc               = r_pc;
  assign pc_valid         = r_pc_valid;
  assign redirect_pending = r_pend_v;
  assign sel_err          = r_sel_err;

endmodule

// File: tb/tb_pc_next_sel.sv
// Scoreboard bench for pc_next_sel: directed test-plan sequences then randomized traffic.
module tb_pc_next_sel;
  import pc_next_pkg::*;

  localparam int W  = 32;
  localparam int NS = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NS*W-1:0] src_data = '0;
  logic [2:0]      sel = '0;
  logic            sel_valid = 1'b0;
  logic            stall = 1'b0;
  logic [W-1:0]    pc;
  logic            pc_valid;
  logic            redirect_pending;
  logic            sel_err;
`ifdef PC_ALIGN_CHECK_EN
  logic            align_err;
`endif

  pc_next_sel #(.WIDTH(32), .NUM_SRC(5), .SEL_W(3), .INC(4), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .src_data         (src_data),
    .sel              (sel),
    .sel_valid        (sel_valid),
    .stall            (stall),
    .pc               (pc),
    .pc_valid         (pc_valid),
    .redirect_pending (redirect_pending),
    .sel_err          (sel_err)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .align_err        (align_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pc;
    bit           pend;
    bit           err;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] src[NS];
  int           checks = 0;
  int           errors = 0;

  // Reference model: architectural PC plus a newest-wins redirect queue of depth one.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_pend[$];
  bit           m_err;

  function automatic void model_reset();
    m_pc = 32'h0;
    m_pend.delete();
    m_err = 1'b0;
  endfunction

  function automatic void model_step(input bit st, input bit sv, input int s);
    bit ok;
    ok    = sv && (s < NS);
    m_err = sv && !ok;
    if (m_err) return;
    if (st) begin
      if (ok) begin
        m_pend.delete();
        m_pend.push_back(src[s]);
      end
    end else if (ok) begin
      m_pc = src[s];
      m_pend.delete();
    end else if (m_pend.size() > 0) begin
      m_pc = m_pend.pop_front();
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_now(input bit st, input bit sv, input int s);
    exp_t e;
    stall     = st;
    sel_valid = sv;
    sel       = 3'(s);
    for (int k = 0; k < NS; k++) src_data[k*W +: W] = src[k];
    model_step(st, sv, s);
    e.pc   = m_pc;
    e.pend = (m_pend.size() != 0);
    e.err  = m_err;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit st, input bit sv, input int s);
    @(negedge clk);
    drive_now(st, sv, s);
  endtask

  // Reset asserted half-way through a cycle; outputs must clear without a clock edge.
  task automatic async_reset();
    @(negedge clk);
    stall = 1'b0; sel_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_pend", {31'b0, redirect_pending}, 32'h0);
    check("async_rst_pvalid", {31'b0, pc_valid}, 32'h0);
    check("async_rst_selerr", {31'b0, sel_err}, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_pc", pc, 32'h0);
    check("rst_rel_pvalid", {31'b0, pc_valid}, 32'h0);
    drive_now(1'b0, 1'b0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        check("pc", pc, e.pc);
        check("pending", {31'b0, redirect_pending}, {31'b0, e.pend});
        check("sel_err", {31'b0, sel_err}, {31'b0, e.err});
        check("pc_valid", {31'b0, pc_valid}, 32'h1);
`ifdef PC_ALIGN_CHECK_EN
        check("align_err", {31'b0, align_err}, 32'h0);
`endif
      end
    end
  end

  initial begin : stim
    int wait_cnt;
    for (int k = 0; k < NS; k++) src[k] = 32'h0;
    model_reset();
    #12;
    check("init_pc", pc, 32'h0);
    check("init_pvalid", {31'b0, pc_valid}, 32'h0);
    check("init_pend", {31'b0, redirect_pending}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_pc", pc, 32'h0);
    check("rel_pvalid", {31'b0, pc_valid}, 32'h0);
    drive_now(1'b0, 1'b0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    src[1] = 32'h0000_0100;
    src[2] = 32'h0000_0400;
    src[3] = 32'h0000_0300;
    src[4] = 32'h8000_0180;
    cyc(0, 1, int'(PC_SRC_JUMP));
    cyc(0, 0, 0);

    cyc(1, 1, int'(PC_SRC_BRANCH));
    cyc(1, 1, int'(PC_SRC_JR));
    cyc(1, 0, 0);
    cyc(0, 0, 0);

    cyc(1, 1, int'(PC_SRC_JR));
    cyc(0, 1, int'(PC_SRC_EXC));
    cyc(0, 0, 0);

    cyc(0, 1, 7);
    cyc(0, 0, 0);
    cyc(1, 1, 6);
    cyc(0, 0, 0);

    src[0] = 32'hFFFF_FFFC;
    cyc(0, 1, int'(PC_SRC_SEQ_ALT));
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    cyc(1, 1, int'(PC_SRC_BRANCH));
    async_reset();
    cyc(0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NS; k++) begin
        src[k] = $urandom();
`ifdef PC_ALIGN_CHECK_EN
        src[k][1:0] = 2'b00;
`endif
      end
      if (n == 200) async_reset();
      cyc(($urandom_range(0, 9) < 4), ($urandom_range(0, 1) == 1), $urandom_range(0, 7));
    end
    cyc(0, 0, 0);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
